// File: rtl/spec_pkg.sv
// Shared constants and FSM state type for the FFT magnitude stream frame buffer.
// No logic; imported by the buffer, its RAM and the FFT control path.
package spec_pkg;

   localparam int POINTS = 2048;
   localparam int DW     = 8;
   localparam int AW     = 11;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

endpackage

// File: rtl/spec_dpram.sv
// Ping-pong frame RAM: one write port and one registered read port; address MSB selects the bank.
// Read data appears one cycle after rd_en; no backpressure, every request is serviced.
module spec_dpram
   import spec_pkg::*;
#(
   parameter int AW = spec_pkg::AW,
   parameter int DW = spec_pkg::DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW:0]   wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW:0]   rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [0:(1 << (AW + 1)) - 1];

   // Storage is deliberately left out of reset so frame contents survive rst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/spec_frame_buf.sv
// AXI4-stream frame buffer: aligns POINTS-bin frames into a ping-pong RAM for a random-access reader.
// Reads return after 1 cycle; s_tready drops while both banks hold complete frames until frame_ack.
module spec_frame_buf
   import spec_pkg::*;
#(
   parameter int POINTS = spec_pkg::POINTS,
   parameter int DW     = spec_pkg::DW,
   parameter int AW     = spec_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] s_tdata,
   input  logic          s_tvalid,
   input  logic          s_tlast,
   output logic          s_tready,
   output logic          frame_rdy,
   input  logic          frame_ack,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          frame_err,
   output logic [15:0]   frame_cnt
);

   localparam logic [AW-1:0] LAST_IDX = AW'(POINTS - 1);

   state_t        state, state_nxt;
   logic [AW-1:0] wr_cnt, wr_cnt_nxt;
   logic          wr_bank, wr_bank_nxt;
   logic          active;
   logic          frame_rdy_nxt;
   logic          frame_err_nxt;
   logic [15:0]   frame_cnt_nxt;

   logic beat;
   logic at_last;
   logic complete;
   logic misalign;
   logic ack;

   // active keeps s_tready low until the first clock after reset is released.
   assign s_tready = active && (state == FILL);
   assign beat     = s_tvalid && s_tready;
   assign at_last  = (wr_cnt == LAST_IDX);
   assign complete = beat && at_last && s_tlast;
   assign misalign = beat && (at_last != s_tlast);
   assign ack      = frame_ack && frame_rdy;

   always_comb begin
      state_nxt     = state;
      wr_cnt_nxt    = wr_cnt;
      wr_bank_nxt   = wr_bank;
      frame_rdy_nxt = frame_rdy;
      frame_cnt_nxt = frame_cnt;
      frame_err_nxt = 1'b0;
      case (state)
         FILL: begin
            if (ack) begin
               frame_rdy_nxt = 1'b0;
            end
            if (complete) begin
               wr_cnt_nxt = '0;
               // An ack in the same cycle frees the read bank, so the new frame swaps in with no gap.
               if (!frame_rdy || ack) begin
                  wr_bank_nxt   = ~wr_bank;
                  frame_rdy_nxt = 1'b1;
                  frame_cnt_nxt = frame_cnt + 16'd1;
               end else begin
                  state_nxt = FULL;
               end
            end else if (misalign) begin
               frame_err_nxt = 1'b1;
               wr_cnt_nxt    = '0;
            end else if (beat) begin
               wr_cnt_nxt = wr_cnt + AW'(1);
            end
         end
         FULL: begin
            if (ack) begin
               wr_bank_nxt   = ~wr_bank;
               frame_cnt_nxt = frame_cnt + 16'd1;
               state_nxt     = FILL;
            end
         end
         default: begin
            state_nxt = FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         wr_cnt    <= '0;
         wr_bank   <= 1'b0;
         active    <= 1'b0;
         frame_rdy <= 1'b0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
         rd_valid  <= 1'b0;
      end else begin
         state     <= state_nxt;
         wr_cnt    <= wr_cnt_nxt;
         wr_bank   <= wr_bank_nxt;
         active    <= 1'b1;
         frame_rdy <= frame_rdy_nxt;
         frame_err <= frame_err_nxt;
         frame_cnt <= frame_cnt_nxt;
         rd_valid  <= rd_en && frame_rdy;
      end
   end

   spec_dpram #(
      .AW (AW),
      .DW (DW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (beat),
      .wr_addr ({wr_bank, wr_cnt}),
      .wr_data (s_tdata),
      .rd_en   (rd_en),
      .rd_addr ({~wr_bank, rd_addr}),
      .rd_data (rd_data)
   );

endmodule

// File: doc/spec_frame_buf.md
# spec_frame_buf

Receive-side frame buffer for the FFT magnitude stream. It acts as an AXI4-stream slave that accepts one spectrum frame of POINTS bins (tvalid/tlast/tready), checks frame alignment, and stores the frame in a ping-pong RAM. A downstream reader (display / VGA spectrum painter) sees a complete frame, reads it by random address, and releases it with an acknowledge. It is the consumer end of the stream produced by the FFT control path.

## Interface
- POINTS, 2048, bins per frame (power of two)
- DW, 8, bin data width
- AW, 11, log2(POINTS)
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- s_tdata  in  DW  bin magnitude
- s_tvalid  in  1  beat valid
- s_tlast  in  1  last bin of frame
- s_tready  out  1  buffer can accept a beat
- frame_rdy  out  1  complete frame available in read bank
- frame_ack  in  1  reader finished; release read bank (ignored while frame_rdy=0)
- rd_en  in  1  read request
- rd_addr  in  AW  bin index
- rd_data  out  DW  bin value, 1-cycle latency
- rd_valid  out  1  rd_data valid
- frame_err  out  1  1-cycle pulse, misaligned frame discarded
- frame_cnt  out  16  frames delivered, wraps at 65535->0

## Operation
- Beat accepted when s_tvalid && s_tready; written to write bank at address wr_cnt, then wr_cnt++.
- States: FILL (s_tready=1), FULL (s_tready=0).
- FILL, accepted beat, wr_cnt==POINTS-1 && s_tlast: frame complete.
  - frame_rdy=0 (read bank free), or frame_ack this cycle: swap banks, frame_rdy=1, frame_cnt++, wr_cnt=0, stay FILL.
  - Otherwise: go FULL, wr_cnt=0.
- FULL: wait for frame_ack; on ack swap banks, frame_rdy stays 1, frame_cnt++, return to FILL next cycle.
- frame_ack in FILL with frame_rdy=1 and no completion: frame_rdy=0.
- Misalignment: s_tlast with wr_cnt<POINTS-1, or wr_cnt==POINTS-1 without s_tlast -> frame_err pulse next cycle, wr_cnt=0, same write bank reused; partial data is never made visible.
- Read: rd_en samples rd_addr on read bank; rd_valid = rd_en && frame_rdy registered; rd_data is undefined when rd_valid=0.
- Bank swap never alters the read bank while frame_rdy=1 and no ack has been given.

## Timing
- Reset values: s_tready=0, frame_rdy=0, rd_valid=0, rd_data=0, frame_err=0, frame_cnt=0, wr_cnt=0, write bank=0, state FILL. s_tready=1 on the first cycle after rst deasserts.
- frame_rdy rises the cycle after the accepting clock edge of the last beat.
- s_tready falls the cycle after the last beat when entering FULL; it rises the cycle after frame_ack.
- Read latency: rd_data/rd_valid valid exactly 1 cycle after rd_en.
- Simultaneous frame completion and frame_ack: the ack is consumed first and the new frame swaps in, so frame_rdy stays high with no dropout cycle and frame_cnt increments once.
- rst mid-frame: partial frame discarded and frame_rdy cleared; RAM contents are not cleared.

## Structure
- Shared package spec_pkg holds:
  - state enum (FILL, FULL)
  - default POINTS/DW/AW constants, shared with the FFT control path
- One sub-module, spec_dpram: simple dual-port RAM, depth 2*POINTS, width DW, one write port and one registered read port; the bank bit is the address MSB.
- Top level contains the FSM, counters, bank select, and error logic.

## Test plan
- Frame of 2048 beats with tdata=i[7:0] and tlast on beat 2047 -> frame_rdy=1 one cycle later; reading addr 5 gives rd_data=5 next cycle; frame_cnt=1.
- Second frame completes with no ack -> s_tready=0 (FULL); frame_ack -> s_tready=1 one cycle later, frame_rdy stays 1; reading addr 5 returns the second frame's value; frame_cnt=2.
- tlast on beat 100 -> frame_err pulse, frame_rdy unchanged; the next clean 2048-beat frame is delivered intact.
- Beat 2047 sent without tlast -> frame_err; no frame_cnt increment.
- Last beat and frame_ack in the same cycle with frame_rdy=1 -> frame_rdy stays 1 with no gap, s_tready stays 1, frame_cnt +1.
- rst asserted at beat 1000 -> all outputs at reset values; a fresh full frame then completes normally with frame_cnt=1.
